id_ex_stage: RTL and testbench

Decode-to-execute pipeline register with operand forwarding and hazard stall, sitting directly upstream of the ALU. It accepts one decoded instruction per cycle from decode and holds it. It resolves RAW hazards against the MEM and WB stages, then presents `alu_op`, `a`, `b`, `shamt` and `ins15_11` to the ALU, along with destination metadata for the EX/MEM register.

---
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX register, the MEM/WB forward sources and the ALU.
// master = environment (decode, MEM/WB, ALU side); slave = id_ex_stage.
interface id_ex_stage_if #(
    parameter int ALU_OP_W = 6,
    parameter int DATA_W   = 32
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [ALU_OP_W-1:0] in_alu_op;
    logic [4:0]          in_shamt;
    logic [4:0]          in_ins15_11;
    logic [4:0]          in_rs;
    logic [4:0]          in_rt;
    logic [4:0]          in_rd;
    logic [DATA_W-1:0]   in_rs_val;
    logic [DATA_W-1:0]   in_rt_val;
    logic [DATA_W-1:0]   in_imm;
    logic                in_use_imm;
    logic                in_wen;
    logic                in_is_load;

    logic                mem_wen;
    logic                mem_is_load;
    logic [4:0]          mem_rd;
    logic [DATA_W-1:0]   mem_val;
    logic                wb_wen;
    logic [4:0]          wb_rd;
    logic [DATA_W-1:0]   wb_val;

    logic                ex_stall;
    logic                out_valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [4:0]          shamt;
    logic [4:0]          ins15_11;
    logic [4:0]          out_rd;
    logic                out_wen;
    logic                out_is_load;

    modport master (
        output flush, in_valid, in_alu_op, in_shamt, in_ins15_11,
               in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm,
               in_use_imm, in_wen, in_is_load,
               mem_wen, mem_is_load, mem_rd, mem_val,
               wb_wen, wb_rd, wb_val, ex_stall,
        input  in_ready, out_valid, alu_op, a, b, shamt, ins15_11,
               out_rd, out_wen, out_is_load
    );

    modport slave (
        input  flush, in_valid, in_alu_op, in_shamt, in_ins15_11,
               in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm,
               in_use_imm, in_wen, in_is_load,
               mem_wen, mem_is_load, mem_rd, mem_val,
               wb_wen, wb_rd, wb_val, ex_stall,
        output in_ready, out_valid, alu_op, a, b, shamt, ins15_11,
               out_rd, out_wen, out_is_load
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard stall and WB capture ahead of the ALU.
// Define ID_EX_FORWARD_EN to add the MEM/WB forwarding mux (stall then covers load-use only).
module id_ex_stage #(
    parameter int ALU_OP_W = 6,
    parameter int DATA_W   = 32
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic                held_valid_q, held_valid_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [4:0]          shamt_q, shamt_d;
    logic [4:0]          ins15_11_q, ins15_11_d;
    logic [4:0]          rs_q, rs_d;
    logic [4:0]          rt_q, rt_d;
    logic [4:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   rs_val_q, rs_val_d;
    logic [DATA_W-1:0]   rt_val_q, rt_val_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                use_imm_q, use_imm_d;
    logic                wen_q, wen_d;
    logic                is_load_q, is_load_d;

    logic              mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;
    logic              hazard, out_valid, fire, in_ready;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // Register 0 is hard-wired, so it never matches a writer.
    always_comb begin
        mem_rs_hit = bus.mem_wen && (bus.mem_rd == rs_q) && (rs_q != 5'd0);
        mem_rt_hit = bus.mem_wen && (bus.mem_rd == rt_q) && (rt_q != 5'd0);
        wb_rs_hit  = bus.wb_wen  && (bus.wb_rd  == rs_q) && (rs_q != 5'd0);
        wb_rt_hit  = bus.wb_wen  && (bus.wb_rd  == rt_q) && (rt_q != 5'd0);
    end

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        rs_fwd = (mem_rs_hit && !bus.mem_is_load) ? bus.mem_val :
                 wb_rs_hit                        ? bus.wb_val  : rs_val_q;
        rt_fwd = (mem_rt_hit && !bus.mem_is_load) ? bus.mem_val :
                 wb_rt_hit                        ? bus.wb_val  : rt_val_q;
        hazard = held_valid_q && bus.mem_is_load &&
                 (mem_rs_hit || (mem_rt_hit && !use_imm_q));
    end
`else
    // MEM value and load flag only feed the forward mux, absent in this build.
    logic unused_fwd_ports;
    assign unused_fwd_ports = ^{bus.mem_val, bus.mem_is_load};

    always_comb begin
        rs_fwd = rs_val_q;
        rt_fwd = rt_val_q;
        hazard = held_valid_q &&
                 (mem_rs_hit || wb_rs_hit ||
                  (!use_imm_q && (mem_rt_hit || wb_rt_hit)));
    end
`endif

    always_comb begin
        out_valid = held_valid_q && !hazard;
        fire      = out_valid && !bus.ex_stall;
        in_ready  = !held_valid_q || fire;
    end

    always_comb begin
        held_valid_d = held_valid_q;
        alu_op_d     = alu_op_q;
        shamt_d      = shamt_q;
        ins15_11_d   = ins15_11_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        rs_val_d     = rs_val_q;
        rt_val_d     = rt_val_q;
        imm_d        = imm_q;
        use_imm_d    = use_imm_q;
        wen_d        = wen_q;
        is_load_d    = is_load_q;
        if (bus.flush) begin
            held_valid_d = 1'b0;
        end else if (bus.in_valid && in_ready) begin
            held_valid_d = 1'b1;
            alu_op_d     = bus.in_alu_op;
            shamt_d      = bus.in_shamt;
            ins15_11_d   = bus.in_ins15_11;
            rs_d         = bus.in_rs;
            rt_d         = bus.in_rt;
            rd_d         = bus.in_rd;
            rs_val_d     = bus.in_rs_val;
            rt_val_d     = bus.in_rt_val;
            imm_d        = bus.in_imm;
            use_imm_d    = bus.in_use_imm;
            wen_d        = bus.in_wen;
            is_load_d    = bus.in_is_load;
        end else begin
            if (fire) held_valid_d = 1'b0;
            // A writeback retiring while we wait would otherwise be lost to the stale RF read.
            if (wb_rs_hit) rs_val_d = bus.wb_val;
            if (wb_rt_hit) rt_val_d = bus.wb_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid_q <= 1'b0;
            alu_op_q     <= '0;
            shamt_q      <= '0;
            ins15_11_q   <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
            wen_q        <= 1'b0;
            is_load_q    <= 1'b0;
        end else begin
            held_valid_q <= held_valid_d;
            alu_op_q     <= alu_op_d;
            shamt_q      <= shamt_d;
            ins15_11_q   <= ins15_11_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
            use_imm_q    <= use_imm_d;
            wen_q        <= wen_d;
            is_load_q    <= is_load_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_op      = alu_op_q;
    assign bus.a           = rs_fwd;
    assign bus.b           = use_imm_q ? imm_q : rt_fwd;
    assign bus.shamt       = shamt_q;
    assign bus.ins15_11    = ins15_11_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_wen     = wen_q;
    assign bus.out_is_load = is_load_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ALU operands queued at issue, checked on fire.
// Stall-cycle expectations follow ID_EX_FORWARD_EN when it is defined for the build.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  shamt;
        logic [4:0]  ins;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    id_ex_stage_if #(.ALU_OP_W(6), .DATA_W(32)) bus ();

    id_ex_stage #(.ALU_OP_W(6), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side();
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_is_load = 1'b0;
        bus.mem_rd      = 5'd0;
        bus.mem_val     = 32'd0;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.wb_val      = 32'd0;
        bus.ex_stall    = 1'b0;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                          input logic [31:0] imm, input logic use_imm, input logic wen,
                          input logic ld, input logic [4:0] shamt, input logic [4:0] ins);
        bus.in_valid    = 1'b1;
        bus.in_alu_op   = op;
        bus.in_rs       = rs;
        bus.in_rt       = rt;
        bus.in_rd       = rd;
        bus.in_rs_val   = rsv;
        bus.in_rt_val   = rtv;
        bus.in_imm      = imm;
        bus.in_use_imm  = use_imm;
        bus.in_wen      = wen;
        bus.in_is_load  = ld;
        bus.in_shamt    = shamt;
        bus.in_ins15_11 = ins;
    endtask

    task automatic push_exp(input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        e.op    = bus.in_alu_op;
        e.shamt = bus.in_shamt;
        e.ins   = bus.in_ins15_11;
        e.rd    = bus.in_rd;
        e.wen   = bus.in_wen;
        e.ld    = bus.in_is_load;
        e.a     = ea;
        e.b     = eb;
        sb_q.push_back(e);
    endtask

    // A transfer to the ALU happens at the coming edge; flushed instructions are never delivered.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && !bus.ex_stall && !bus.flush) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_fire", 64'(1), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("fire_a", 64'(bus.a), 64'(mon_e.a));
                chk("fire_b", 64'(bus.b), 64'(mon_e.b));
                chk("fire_ctl",
                    64'({bus.alu_op, bus.shamt, bus.ins15_11, bus.out_rd, bus.out_wen, bus.out_is_load}),
                    64'({mon_e.op, mon_e.shamt, mon_e.ins, mon_e.rd, mon_e.wen, mon_e.ld}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r_rsv, r_rtv, r_imm;
        logic        r_ui;

        rst = 1'b1;
        clear_side();
        set_in(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        bus.in_valid = 1'b0;
        tick(); tick();
        #2;
        chk("rst_vld", 64'(bus.out_valid), 64'(0));
        chk("rst_rdy", 64'(bus.in_ready), 64'(1));
        rst = 1'b0;
        tick(); #2;
        chk("rst_a", 64'(bus.a), 64'(0));
        chk("rst_b", 64'(bus.b), 64'(0));
        chk("rst_ctl", 64'({bus.alu_op, bus.shamt, bus.ins15_11, bus.out_rd, bus.out_wen, bus.out_is_load}), 64'(0));

        // MEM non-load producer on rs
        set_in(6'h20, 5'd3, 5'd6, 5'd8, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd8);
        push_exp(32'h10, 32'h7);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_wen = 1'b1; bus.mem_rd = 5'd3; bus.mem_val = 32'h10; bus.mem_is_load = 1'b0;
        #2;
        chk("memfwd_c1_vld", 64'(bus.out_valid), 64'(FWD));
        chk("memfwd_c1_a", 64'(bus.a), FWD ? 64'h10 : 64'h5);
        tick();
        clear_side();
        bus.wb_wen = 1'b1; bus.wb_rd = 5'd3; bus.wb_val = 32'h10;
        #2;
        chk("memfwd_c2_vld", 64'(bus.out_valid), 64'(0));
        tick();
        clear_side(); #2;
        chk("memfwd_c3_vld", 64'(bus.out_valid), 64'(!FWD));
        tick();

        // Load-use on rs: MEM load, then WB delivers the data
        set_in(6'h21, 5'd4, 5'd9, 5'd10, 32'd1, 32'd3, 32'd2, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        push_exp(32'hABCD, 32'd2);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_wen = 1'b1; bus.mem_is_load = 1'b1; bus.mem_rd = 5'd4; bus.mem_val = 32'hDEAD;
        #2;
        chk("lu_c1_vld", 64'(bus.out_valid), 64'(0));
        chk("lu_c1_rdy", 64'(bus.in_ready), 64'(0));
        tick();
        clear_side();
        bus.wb_wen = 1'b1; bus.wb_rd = 5'd4; bus.wb_val = 32'hABCD;
        #2;
        chk("lu_c2_vld", 64'(bus.out_valid), 64'(FWD));
        chk("lu_c2_a", 64'(bus.a), FWD ? 64'hABCD : 64'h1);
        tick();
        clear_side(); #2;
        chk("lu_c3_vld", 64'(bus.out_valid), 64'(!FWD));
        tick();

        // Immediate operand: a MEM load to the unused rt must not stall
        set_in(6'h22, 5'd0, 5'd5, 5'd11, 32'd9, 32'h12, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd4);
        push_exp(32'd9, 32'hFFFF_FFF0);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_wen = 1'b1; bus.mem_is_load = 1'b1; bus.mem_rd = 5'd5; bus.mem_val = 32'h5555;
        #2;
        chk("imm_vld", 64'(bus.out_valid), 64'(1));
        chk("imm_b", 64'(bus.b), 64'hFFFF_FFF0);
        tick();
        clear_side();

        // r0 sources: no stall, no forward, no capture
        set_in(6'h26, 5'd0, 5'd0, 5'd1, 32'h44, 32'h45, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        push_exp(32'h44, 32'h45);
        tick();
        bus.in_valid = 1'b0; bus.ex_stall = 1'b1;
        bus.mem_wen = 1'b1; bus.mem_rd = 5'd0; bus.mem_val = 32'd7; bus.mem_is_load = 1'b1;
        bus.wb_wen = 1'b1; bus.wb_rd = 5'd0; bus.wb_val = 32'h77;
        #2;
        chk("r0_vld", 64'(bus.out_valid), 64'(1));
        chk("r0_a", 64'(bus.a), 64'h44);
        chk("r0_b", 64'(bus.b), 64'h45);
        tick();
        clear_side(); #2;
        chk("r0_a_after_wb", 64'(bus.a), 64'h44);
        tick();

        // Downstream stall for 3 cycles with decode waiting, then fire+accept at one edge
        set_in(6'h23, 5'd7, 5'd8, 5'd9, 32'h70, 32'h80, 32'd0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2);
        push_exp(32'h70, 32'h80);
        tick();
        bus.ex_stall = 1'b1;
        set_in(6'h24, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hB0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd7);
        push_exp(32'hA0, 32'hB0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_rdy", 64'(bus.in_ready), 64'(0));
            chk("stall_vld", 64'(bus.out_valid), 64'(1));
            chk("stall_a", 64'(bus.a), 64'h70);
            tick();
        end
        bus.ex_stall = 1'b0;
        #2;
        chk("release_rdy", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        #2;
        chk("b2b_next_vld", 64'(bus.out_valid), 64'(1));
        chk("b2b_next_a", 64'(bus.a), 64'hA0);
        tick();

        // WB arriving while held by downstream stall is captured
        set_in(6'h25, 5'd13, 5'd14, 5'd15, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        push_exp(32'h1300, 32'd2);
        tick();
        bus.in_valid = 1'b0; bus.ex_stall = 1'b1;
        bus.wb_wen = 1'b1; bus.wb_rd = 5'd13; bus.wb_val = 32'h1300;
        #2;
        chk("cap_c1_vld", 64'(bus.out_valid), 64'(FWD));
        tick();
        clear_side(); bus.ex_stall = 1'b1;
        #2;
        chk("cap_c2_vld", 64'(bus.out_valid), 64'(1));
        chk("cap_c2_a", 64'(bus.a), 64'h1300);
        tick();
        bus.ex_stall = 1'b0;
        tick();

        // Independent back-to-back stream at full rate
        for (int i = 0; i < 6; i++) begin
            r_rsv = $urandom();
            r_rtv = $urandom();
            r_imm = $urandom();
            r_ui  = 1'($urandom_range(0, 1));
            set_in(6'(i + 1), 5'(16 + i), 5'(24 + i), 5'(i + 1), r_rsv, r_rtv, r_imm, r_ui,
                   1'(i % 2), 1'b0, 5'(i), 5'(31 - i));
            push_exp(r_rsv, r_ui ? r_imm : r_rtv);
            #1;
            chk("bb_rdy", 64'(bus.in_ready), 64'(1));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();

        // Flush beats a simultaneous new instruction
        set_in(6'h27, 5'd1, 5'd2, 5'd3, 32'd11, 32'd12, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        bus.flush = 1'b1;
        set_in(6'h28, 5'd1, 5'd2, 5'd3, 32'd21, 32'd22, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        #2;
        chk("flush_rdy", 64'(bus.in_ready), 64'(1));
        tick();
        clear_side(); #2;
        chk("flush_vld", 64'(bus.out_valid), 64'(0));
        chk("flush_rdy_after", 64'(bus.in_ready), 64'(1));
        tick();

        // Asynchronous reset while holding a stalled instruction
        set_in(6'h29, 5'd5, 5'd6, 5'd7, 32'h51, 32'h61, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0);
        tick();
        bus.in_valid = 1'b0; bus.ex_stall = 1'b1;
        #2;
        chk("rm_vld_pre", 64'(bus.out_valid), 64'(1));
        tick();
        rst = 1'b1;
        #1;
        chk("rm_vld", 64'(bus.out_valid), 64'(0));
        chk("rm_rdy", 64'(bus.in_ready), 64'(1));
        chk("rm_a", 64'(bus.a), 64'(0));
        chk("rm_b", 64'(bus.b), 64'(0));
        tick();
        rst = 1'b0;
        clear_side();
        tick(); tick();

        chk("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
